// File: rtl/stm_index_gen.sv
// Per-segment STM sample index generator: a free-running clock divider and a
// wrapping index counter for each of the two segments, with freeze-on-STOP.
module stm_index_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UPDATE_SETTINGS,
  input  logic [15:0] CYCLE_0,
  input  logic [15:0] CYCLE_1,
  input  logic [15:0] FREQ_DIV_0,
  input  logic [15:0] FREQ_DIV_1,
  input  logic        SEGMENT,
  input  logic        STOP,
  output logic [15:0] IDX_0,
  output logic [15:0] IDX_1,
  output logic        WRAP_0,
  output logic        WRAP_1
);

  logic [15:0] cycle_in [2];
  logic [15:0] div_in   [2];
  logic [15:0] cycle_q  [2];
  logic [15:0] div_q    [2];
  logic [15:0] dcnt_q   [2];
  logic [15:0] idx_q    [2];
  logic [1:0]  wrap_q;
  logic [1:0]  frozen;

  assign cycle_in[0] = CYCLE_0;
  assign cycle_in[1] = CYCLE_1;
  assign div_in[0]   = FREQ_DIV_0;
  assign div_in[1]   = FREQ_DIV_1;

  // Only the active segment is frozen; the other keeps running so the
  // swapchain can see it come back around to index 0.
  assign frozen = {STOP & SEGMENT, STOP & ~SEGMENT};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // cycle 0 / div 1: index parked at 0 with a wrap pulse every cycle
      for (int s = 0; s < 2; s++) begin
        cycle_q[s] <= 16'd0;
        div_q[s]   <= 16'd1;
        dcnt_q[s]  <= 16'd0;
        idx_q[s]   <= 16'd0;
        wrap_q[s]  <= 1'b0;
      end
    end else if (UPDATE_SETTINGS) begin
      for (int s = 0; s < 2; s++) begin
        cycle_q[s] <= cycle_in[s];
        div_q[s]   <= (div_in[s] == 16'd0) ? 16'd1 : div_in[s];
        dcnt_q[s]  <= 16'd0;
        idx_q[s]   <= 16'd0;
        wrap_q[s]  <= 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (frozen[s]) begin
          wrap_q[s] <= 1'b0;
        end else if (dcnt_q[s] == div_q[s] - 16'd1) begin
          dcnt_q[s] <= 16'd0;
          if (idx_q[s] == cycle_q[s]) begin
            idx_q[s]  <= 16'd0;
            wrap_q[s] <= 1'b1;
          end else begin
            idx_q[s]  <= idx_q[s] + 16'd1;
            wrap_q[s] <= 1'b0;
          end
        end else begin
          dcnt_q[s] <= dcnt_q[s] + 16'd1;
          wrap_q[s] <= 1'b0;
        end
      end
    end
  end

  assign IDX_0  = idx_q[0];
  assign IDX_1  = idx_q[1];
  assign WRAP_0 = wrap_q[0];
  assign WRAP_1 = wrap_q[1];

endmodule

// File: tb/tb_stm_index_gen.sv
// Self-checking bench for stm_index_gen; the reference model tracks each
// segment's count of unfrozen clocks since restart and derives index/wrap.
module tb_stm_index_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [15:0] cyc0 = '0, cyc1 = '0, div0 = '0, div1 = '0;
  logic        seg = 1'b0, stop = 1'b0;
  logic [15:0] idx0, idx1;
  logic        wrap0, wrap1;

  int checks = 0;
  int errors = 0;

  // model state
  longint m_t     [2];
  longint m_cycle [2];
  longint m_div   [2];
  logic   m_wrap  [2];

  stm_index_gen dut (
    .CLK(clk), .RST(rst), .UPDATE_SETTINGS(upd),
    .CYCLE_0(cyc0), .CYCLE_1(cyc1), .FREQ_DIV_0(div0), .FREQ_DIV_1(div1),
    .SEGMENT(seg), .STOP(stop),
    .IDX_0(idx0), .IDX_1(idx1), .WRAP_0(wrap0), .WRAP_1(wrap1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_idx(input int s);
    return 16'((m_t[s] / m_div[s]) % (m_cycle[s] + 1));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_t[s] = 0; m_cycle[s] = 0; m_div[s] = 1; m_wrap[s] = 1'b0;
    end
  endtask

  task automatic model_edge();
    longint c [2];
    longint d [2];
    c[0] = longint'(cyc0); c[1] = longint'(cyc1);
    d[0] = longint'(div0); d[1] = longint'(div1);
    for (int s = 0; s < 2; s++) begin
      if (upd) begin
        m_cycle[s] = c[s];
        m_div[s]   = (d[s] == 0) ? 1 : d[s];
        m_t[s]     = 0;
        m_wrap[s]  = 1'b0;
      end else if (stop && (int'(seg) == s)) begin
        m_wrap[s] = 1'b0;
      end else begin
        m_t[s]++;
        m_wrap[s] = (m_t[s] % m_div[s] == 0) && (exp_idx(s) == 16'd0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e0, e1;
    e0 = exp_idx(0);
    e1 = exp_idx(1);
    checks++;
    assert (idx0 === e0) else begin
      errors++; $error("FAIL %s idx0: got %0d expected %0d", tag, idx0, e0);
    end
    checks++;
    assert (idx1 === e1) else begin
      errors++; $error("FAIL %s idx1: got %0d expected %0d", tag, idx1, e1);
    end
    checks++;
    assert (wrap0 === m_wrap[0]) else begin
      errors++; $error("FAIL %s wrap0: got %b expected %b", tag, wrap0, m_wrap[0]);
    end
    checks++;
    assert (wrap1 === m_wrap[1]) else begin
      errors++; $error("FAIL %s wrap1: got %b expected %b", tag, wrap1, m_wrap[1]);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_update(input logic [15:0] c0, input logic [15:0] d0,
                           input logic [15:0] c1, input logic [15:0] d1,
                           input string tag);
    cyc0 = c0; div0 = d0; cyc1 = c1; div1 = d1;
    upd = 1'b1;
    step(tag);
    upd = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset_held");
    rst = 1'b0;
    #1;
    check_all("reset_release");
    for (int i = 0; i < 4; i++) step("reset_defaults");

    // basic stepping: 0,0,1,1,2,2,3,3,0 with wrap every 8 cycles
    do_update(16'd3, 16'd2, 16'd2, 16'd0, "basic_upd");
    for (int i = 0; i < 18; i++) step("basic_div0seg1");

    // stop on segment 0 with a partial divider count of 2
    do_update(16'd7, 16'd4, 16'd2, 16'd1, "stop_upd");
    for (int i = 0; i < 6; i++) step("stop_pre");
    seg = 1'b0; stop = 1'b1;
    for (int i = 0; i < 5; i++) step("stop_held");
    stop = 1'b0;
    for (int i = 0; i < 6; i++) step("stop_resume");

    // update overrides stop while idx0 = 5
    do_update(16'd9, 16'd1, 16'd9, 16'd1, "ovr_upd");
    for (int i = 0; i < 5; i++) step("ovr_pre");
    checks++;
    assert (idx0 === 16'd5) else begin
      errors++; $error("FAIL ovr_setup idx0: got %0d expected 5", idx0);
    end
    stop = 1'b1; seg = 1'b0;
    do_update(16'd9, 16'd1, 16'd9, 16'd1, "ovr_hit");
    stop = 1'b0;
    for (int i = 0; i < 3; i++) step("ovr_post");

    // async reset between edges while idx1 = 7
    do_update(16'd4, 16'd3, 16'd9, 16'd1, "arst_upd");
    for (int i = 0; i < 7; i++) step("arst_pre");
    checks++;
    assert (idx1 === 16'd7) else begin
      errors++; $error("FAIL arst_setup idx1: got %0d expected 7", idx1);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst_async");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("arst_post");

    // randomized operation, including segment switches during stop
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cyc0 = 16'($urandom_range(0, 5));
        cyc1 = 16'($urandom_range(0, 5));
        div0 = 16'($urandom_range(0, 4));
        div1 = 16'($urandom_range(0, 4));
        upd  = 1'b1;
      end else begin
        upd = 1'b0;
      end
      stop = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) seg = ~seg;
      step("random");
    end
    upd = 1'b0; stop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
